// File: rtl/decode_queue.sv
// MIPS decode stage: DEPTH-entry {instr,pc} FIFO feeding a registered decoder output slot.
// Valid/ready on both sides; w_flush empties the FIFO and the output slot at once.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             w_in_valid,
    output logic             w_in_ready,
    input  logic [31:0]      w_in_instr_32,
    input  logic [31:0]      w_in_pc_32,
    input  logic             w_flush,
    input  logic             w_out_ready,
    output logic             w_out_valid,
    output logic [31:0]      w_out_instr_32,
    output logic [31:0]      w_out_pc_32,
    output logic             w_alu_op,
    output logic             w_unsigned_op,
    output logic             w_imm_op,
    output logic             w_byte_op,
    output logic             w_shift_op,
    output logic             w_mem_op,
    output logic             w_write_op,
    output logic             w_branch_op,
    output logic             w_jump_op,
    output logic             w_nop,
    output logic [5:0]       w_op_type_6,
    output logic [4:0]       w_rs_addr_5,
    output logic [4:0]       w_rt_addr_5,
    output logic [4:0]       w_rd_addr_5,
    output logic [4:0]       w_sh_amt_5,
    output logic [5:0]       w_func_6,
    output logic [15:0]      w_alu_imm_val_16,
    output logic [25:0]      w_branch_imm_val_26,
    output logic [CNT_W-1:0] w_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push, pop;
    logic [31:0]      head_instr, head_pc;
    logic [5:0]       opcode, func;
    logic [4:0]       rt, shamt;

    logic d_alu, d_uns, d_imm, d_byte, d_shift, d_mem, d_write, d_branch, d_jump, d_nop;
    logic [5:0] d_op_type;

    assign w_count    = count_q;
    assign w_in_ready = (count_q < CNT_W'(DEPTH));
    assign push       = w_in_valid && w_in_ready && !w_flush;
    assign pop        = (count_q != '0) && (!w_out_valid || w_out_ready) && !w_flush;

    assign {head_instr, head_pc} = mem_q[rd_ptr_q];
    assign opcode = head_instr[31:26];
    assign func   = head_instr[5:0];
    assign rt     = head_instr[20:16];
    assign shamt  = head_instr[10:6];

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= {w_in_instr_32, w_in_pc_32};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (w_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    always_comb begin
        d_alu = 1'b0; d_uns = 1'b0; d_imm = 1'b0; d_byte = 1'b0; d_shift = 1'b0;
        d_mem = 1'b0; d_write = 1'b0; d_branch = 1'b0; d_jump = 1'b0; d_nop = 1'b0;
        d_op_type = opcode;
        case (opcode)
            6'h00: begin
                d_op_type = func;
                case (func)
                    6'h08, 6'h09: d_jump = 1'b1;
                    6'h21, 6'h23, 6'h19, 6'h1B, 6'h2B: begin d_alu = 1'b1; d_uns = 1'b1; end
                    6'h20, 6'h22, 6'h18, 6'h1A, 6'h2A,
                    6'h24, 6'h25, 6'h26, 6'h27: d_alu = 1'b1;
                    6'h02, 6'h03: begin d_alu = 1'b1; d_imm = 1'b1; d_shift = 1'b1; end
                    // SLL with zero shift is the canonical MIPS nop
                    6'h00: begin
                        if (shamt != '0) begin d_alu = 1'b1; d_imm = 1'b1; d_shift = 1'b1; end
                        else d_nop = 1'b1;
                    end
                    6'h04, 6'h06, 6'h07: begin d_alu = 1'b1; d_shift = 1'b1; end
                    default: d_nop = 1'b1;
                endcase
            end
            6'h01: begin
                if (rt == 5'h00 || rt == 5'h01) begin
                    d_branch  = 1'b1;
                    d_op_type = {1'b0, rt};
                end else begin
                    d_nop     = 1'b1;
                    d_op_type = '0;
                end
            end
            6'h09, 6'h0B:        begin d_alu = 1'b1; d_imm = 1'b1; d_uns = 1'b1; end
            6'h0A, 6'h0D, 6'h0E: begin d_alu = 1'b1; d_imm = 1'b1; end
            6'h23: d_mem = 1'b1;
            6'h20: begin d_mem = 1'b1; d_byte = 1'b1; end
            6'h24: begin d_mem = 1'b1; d_byte = 1'b1; d_uns = 1'b1; end
            6'h2B: begin d_mem = 1'b1; d_write = 1'b1; end
            6'h28: begin d_mem = 1'b1; d_byte = 1'b1; d_write = 1'b1; end
            6'h0F: begin d_mem = 1'b1; d_imm = 1'b1; end
            6'h02, 6'h03: begin d_jump = 1'b1; d_imm = 1'b1; end
            6'h04, 6'h05, 6'h06, 6'h07: d_branch = 1'b1;
            default: begin
                d_nop     = 1'b1;
                d_op_type = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_out_valid         <= 1'b0;
            w_out_instr_32      <= '0;
            w_out_pc_32         <= '0;
            w_alu_op            <= 1'b0;
            w_unsigned_op       <= 1'b0;
            w_imm_op            <= 1'b0;
            w_byte_op           <= 1'b0;
            w_shift_op          <= 1'b0;
            w_mem_op            <= 1'b0;
            w_write_op          <= 1'b0;
            w_branch_op         <= 1'b0;
            w_jump_op           <= 1'b0;
            w_nop               <= 1'b0;
            w_op_type_6         <= '0;
            w_rs_addr_5         <= '0;
            w_rt_addr_5         <= '0;
            w_rd_addr_5         <= '0;
            w_sh_amt_5          <= '0;
            w_func_6            <= '0;
            w_alu_imm_val_16    <= '0;
            w_branch_imm_val_26 <= '0;
        end else if (w_flush) begin
            w_out_valid <= 1'b0;
        end else if (pop) begin
            w_out_valid         <= 1'b1;
            w_out_instr_32      <= head_instr;
            w_out_pc_32         <= head_pc;
            w_alu_op            <= d_alu;
            w_unsigned_op       <= d_uns;
            w_imm_op            <= d_imm;
            w_byte_op           <= d_byte;
            w_shift_op          <= d_shift;
            w_mem_op            <= d_mem;
            w_write_op          <= d_write;
            w_branch_op         <= d_branch;
            w_jump_op           <= d_jump;
            w_nop               <= d_nop;
            w_op_type_6         <= d_op_type;
            w_rs_addr_5         <= head_instr[25:21];
            w_rt_addr_5         <= head_instr[20:16];
            w_rd_addr_5         <= head_instr[15:11];
            w_sh_amt_5          <= head_instr[10:6];
            w_func_6            <= head_instr[5:0];
            w_alu_imm_val_16    <= head_instr[15:0];
            w_branch_imm_val_26 <= head_instr[25:0];
        end else if (w_out_ready) begin
            w_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode table, backpressure, streaming, flush, async reset.
module tb_decode_queue;
    logic        clock = 1'b0;
    logic        reset;
    logic        w_in_valid, w_in_ready, w_flush, w_out_ready, w_out_valid;
    logic [31:0] w_in_instr_32, w_in_pc_32, w_out_instr_32, w_out_pc_32;
    logic        w_alu_op, w_unsigned_op, w_imm_op, w_byte_op, w_shift_op;
    logic        w_mem_op, w_write_op, w_branch_op, w_jump_op, w_nop;
    logic [5:0]  w_op_type_6, w_func_6;
    logic [4:0]  w_rs_addr_5, w_rt_addr_5, w_rd_addr_5, w_sh_amt_5;
    logic [15:0] w_alu_imm_val_16;
    logic [25:0] w_branch_imm_val_26;
    logic [2:0]  w_count;
    logic [9:0]  flags;
    logic [66:0] fields;

    int total = 0;
    int bad   = 0;

    assign flags = {w_alu_op, w_unsigned_op, w_imm_op, w_byte_op, w_shift_op,
                    w_mem_op, w_write_op, w_branch_op, w_jump_op, w_nop};
    assign fields = {w_rs_addr_5, w_rt_addr_5, w_rd_addr_5, w_sh_amt_5, w_func_6,
                     w_alu_imm_val_16, w_branch_imm_val_26};

    always #5 clock = ~clock;

    decode_queue #(.DEPTH(4), .CNT_W(3)) dut (
        .clock(clock), .reset(reset),
        .w_in_valid(w_in_valid), .w_in_ready(w_in_ready),
        .w_in_instr_32(w_in_instr_32), .w_in_pc_32(w_in_pc_32),
        .w_flush(w_flush), .w_out_ready(w_out_ready), .w_out_valid(w_out_valid),
        .w_out_instr_32(w_out_instr_32), .w_out_pc_32(w_out_pc_32),
        .w_alu_op(w_alu_op), .w_unsigned_op(w_unsigned_op), .w_imm_op(w_imm_op),
        .w_byte_op(w_byte_op), .w_shift_op(w_shift_op), .w_mem_op(w_mem_op),
        .w_write_op(w_write_op), .w_branch_op(w_branch_op), .w_jump_op(w_jump_op),
        .w_nop(w_nop), .w_op_type_6(w_op_type_6),
        .w_rs_addr_5(w_rs_addr_5), .w_rt_addr_5(w_rt_addr_5), .w_rd_addr_5(w_rd_addr_5),
        .w_sh_amt_5(w_sh_amt_5), .w_func_6(w_func_6),
        .w_alu_imm_val_16(w_alu_imm_val_16), .w_branch_imm_val_26(w_branch_imm_val_26),
        .w_count(w_count)
    );

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        w_in_valid = v; w_in_instr_32 = instr; w_in_pc_32 = pc;
    endtask

    task automatic test_reset;
        reset = 1'b1; w_flush = 1'b0; w_out_ready = 1'b1; drive(1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total++; if (w_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", w_out_valid); end
        total++; if (w_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", w_count); end
        total++; if (w_in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", w_in_ready); end
        total++; if ({w_out_instr_32, w_out_pc_32, flags, w_op_type_6, fields} !== '0) begin
            bad++; $display("FAIL rst_outputs got instr=%h pc=%h flags=%b exp all 0",
                            w_out_instr_32, w_out_pc_32, flags);
        end
    endtask

    task automatic test_basic;
        @(negedge clock); drive(1'b1, 32'h00851021, 32'h100);
        @(negedge clock); drive(1'b0, 32'h0, 32'h0);
        @(negedge clock);
        total++; if (w_out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", w_out_valid); end
        total++; if (flags !== 10'b1100000000 || w_op_type_6 !== 6'h21) begin
            bad++; $display("FAIL basic_decode got flags=%b op=%h exp flags=1100000000 op=21", flags, w_op_type_6);
        end
        total++; if ({w_rs_addr_5, w_rt_addr_5, w_rd_addr_5} !== {5'd4, 5'd5, 5'd2}) begin
            bad++; $display("FAIL basic_regs got rs=%0d rt=%0d rd=%0d exp 4 5 2", w_rs_addr_5, w_rt_addr_5, w_rd_addr_5);
        end
        total++; if (w_out_pc_32 !== 32'h100 || w_out_instr_32 !== 32'h00851021) begin
            bad++; $display("FAIL basic_pc got pc=%h instr=%h exp 100 00851021", w_out_pc_32, w_out_instr_32);
        end
        total++; if (w_count !== 3'd0) begin bad++; $display("FAIL basic_count got=%0d exp=0", w_count); end
        @(negedge clock);
        total++; if (w_out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", w_out_valid); end
    endtask

    task automatic test_decode_corners;
        logic [31:0] ci [14] = '{32'h00000000, 32'h00021080, 32'h04010004, 32'h04110004,
                                 32'h90A20003, 32'h00851021, 32'h34A20001, 32'h08000004,
                                 32'h00A01008, 32'hAC850000, 32'h00851004, 32'h24A2FFFF,
                                 32'hFC000000, 32'h0000000C};
        logic [9:0]  cf [14] = '{10'b0000000001, 10'b1010100000, 10'b0000000100, 10'b0000000001,
                                 10'b0101010000, 10'b1100000000, 10'b1010000000, 10'b0010000010,
                                 10'b0000000010, 10'b0000011000, 10'b1000100000, 10'b1110000000,
                                 10'b0000000001, 10'b0000000001};
        // bit 6 set: op_type is checked against bits [5:0]
        logic [6:0]  co [14] = '{7'h40, 7'h40, 7'h41, 7'h40, 7'h00, 7'h61, 7'h4D, 7'h00,
                                 7'h48, 7'h00, 7'h44, 7'h49, 7'h40, 7'h4C};
        logic [31:0] x;
        for (int i = 0; i < 14; i++) begin
            x = ci[i];
            @(negedge clock); drive(1'b1, x, 32'h400 + 32'(i) * 4);
            @(negedge clock); drive(1'b0, 32'h0, 32'h0);
            @(negedge clock);
            total++; if (w_out_valid !== 1'b1 || flags !== cf[i]) begin
                bad++; $display("FAIL dec_flags[%0d] instr=%h got v=%b flags=%b exp v=1 flags=%b",
                                i, x, w_out_valid, flags, cf[i]);
            end
            if (co[i][6]) begin
                total++; if (w_op_type_6 !== co[i][5:0]) begin
                    bad++; $display("FAIL dec_op[%0d] got=%h exp=%h", i, w_op_type_6, co[i][5:0]);
                end
            end
            total++; if (fields !== {x[25:21], x[20:16], x[15:11], x[10:6], x[5:0], x[15:0], x[25:0]}
                         || w_out_pc_32 !== 32'h400 + 32'(i) * 4) begin
                bad++; $display("FAIL dec_fields[%0d] got fields=%h pc=%h", i, fields, w_out_pc_32);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_fill_backpressure;
        int idx = 0;
        logic acc;
        w_out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            drive(idx < 6, 32'h00851021, 32'h200 + 32'(idx) * 4);
            acc = w_in_ready;
            @(posedge clock);
            if (acc && idx < 6) idx++;
        end
        @(negedge clock);
        total++; if (idx !== 5) begin bad++; $display("FAIL fill_accepted got=%0d exp=5", idx); end
        total++; if (w_count !== 3'd4 || w_in_ready !== 1'b0) begin
            bad++; $display("FAIL fill_full got count=%0d ready=%b exp 4 0", w_count, w_in_ready);
        end
        total++; if (w_out_valid !== 1'b1 || w_out_pc_32 !== 32'h200) begin
            bad++; $display("FAIL fill_hold got v=%b pc=%h exp 1 200", w_out_valid, w_out_pc_32);
        end
        w_out_ready = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            drive(idx < 6, 32'h00851021, 32'h200 + 32'(idx) * 4);
            acc = w_in_ready;
            @(posedge clock);
            if (acc && idx < 6) idx++;
            @(negedge clock);
            total++; if (w_out_valid !== 1'b1 || w_out_pc_32 !== 32'h200 + 32'(e) * 4) begin
                bad++; $display("FAIL drain[%0d] got v=%b pc=%h exp pc=%h", e, w_out_valid, w_out_pc_32,
                                32'h200 + 32'(e) * 4);
            end
        end
        drive(1'b0, 32'h0, 32'h0);
        total++; if (idx !== 6 || w_count !== 3'd0) begin
            bad++; $display("FAIL drain_end got idx=%0d count=%0d exp 6 0", idx, w_count);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back;
        w_out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (c >= 2) begin
                total++; if (w_out_valid !== 1'b1 || w_out_pc_32 !== 32'(c - 2) * 4) begin
                    bad++; $display("FAIL stream[%0d] got v=%b pc=%h exp pc=%h", c, w_out_valid,
                                    w_out_pc_32, 32'(c - 2) * 4);
                end
            end
            total++; if (w_count > 3'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d exp<=1", c, w_count); end
            drive(c < 8, 32'h00851021, 32'(c) * 4);
        end
        @(negedge clock);
        total++; if (w_out_valid !== 1'b0) begin bad++; $display("FAIL stream_end got=%b exp=0", w_out_valid); end
    endtask

    task automatic test_flush;
        w_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h00851021, 32'h300 + 32'(i) * 4);
            @(negedge clock);
        end
        total++; if (w_count !== 3'd3 || w_out_valid !== 1'b1) begin
            bad++; $display("FAIL flush_pre got count=%0d v=%b exp 3 1", w_count, w_out_valid);
        end
        drive(1'b1, 32'h00851021, 32'h3F0);
        w_flush = 1'b1;
        @(negedge clock);
        w_flush = 1'b0; drive(1'b0, 32'h0, 32'h0);
        total++; if (w_out_valid !== 1'b0 || w_count !== 3'd0 || w_in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_post got v=%b count=%0d ready=%b exp 0 0 1", w_out_valid, w_count, w_in_ready);
        end
        w_out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            total++; if (w_out_valid !== 1'b0) begin
                bad++; $display("FAIL flush_leak[%0d] got v=%b pc=%h exp v=0", c, w_out_valid, w_out_pc_32);
            end
        end
        drive(1'b1, 32'h00851021, 32'h3A0);
        @(negedge clock); drive(1'b0, 32'h0, 32'h0);
        @(negedge clock);
        total++; if (w_out_valid !== 1'b1 || w_out_pc_32 !== 32'h3A0) begin
            bad++; $display("FAIL flush_resume got v=%b pc=%h exp 1 3a0", w_out_valid, w_out_pc_32);
        end
        @(negedge clock);
    endtask

    task automatic test_async_reset;
        w_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00851021, 32'h500 + 32'(i) * 4);
            @(negedge clock);
        end
        drive(1'b0, 32'h0, 32'h0);
        total++; if (w_count !== 3'd2 || w_out_valid !== 1'b1) begin
            bad++; $display("FAIL arst_pre got count=%0d v=%b exp 2 1", w_count, w_out_valid);
        end
        #2 reset = 1'b1;
        #1;
        total++; if (w_out_valid !== 1'b0 || w_count !== 3'd0 || w_in_ready !== 1'b1) begin
            bad++; $display("FAIL arst_now got v=%b count=%0d ready=%b exp 0 0 1", w_out_valid, w_count, w_in_ready);
        end
        total++; if ({w_out_instr_32, w_out_pc_32, flags, w_op_type_6, fields} !== '0) begin
            bad++; $display("FAIL arst_outputs got instr=%h pc=%h flags=%b exp all 0", w_out_instr_32, w_out_pc_32, flags);
        end
        #1 reset = 1'b0;
        w_out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            total++; if (w_out_valid !== 1'b0 || w_out_pc_32 !== 32'h0 || flags !== 10'b0) begin
                bad++; $display("FAIL arst_hold[%0d] got v=%b pc=%h flags=%b exp 0", c, w_out_valid, w_out_pc_32, flags);
            end
        end
        drive(1'b1, 32'h34A20001, 32'h600);
        @(negedge clock); drive(1'b0, 32'h0, 32'h0);
        @(negedge clock);
        total++; if (w_out_valid !== 1'b1 || w_out_pc_32 !== 32'h600) begin
            bad++; $display("FAIL arst_resume got v=%b pc=%h exp 1 600", w_out_valid, w_out_pc_32);
        end
        @(negedge clock);
        total++; if (w_out_valid !== 1'b0 || w_count !== 3'd0) begin
            bad++; $display("FAIL arst_stale got v=%b count=%0d pc=%h exp 0 0", w_out_valid, w_count, w_out_pc_32);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_decode_corners();
        test_fill_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
